largest_num_divisible_by_k: RTL and testbench

- Parametrised successor to the fixed divide-by-7 array search.
- Scans an internal array of DEPTH unsigned W-bit numbers and finds the largest (mode 0) or smallest (mode 1) non-zero entry evenly divisible by a run-time divisor K. Divisibility is tested by repeated subtraction.
- The array is loaded through a write port while the block is idle. Sits as a stand-alone RTL exercise datapath+CU with one-hot state outputs for the top-level display.

---
 rtl/largest_num_divisible_by_k_pkg.sv | 19 +
 rtl/largest_num_divisible_by_k_check.sv | 48 ++++
 rtl/largest_num_divisible_by_k.sv | 172 +++++++++++++++++
 tb/tb_largest_num_divisible_by_k.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/largest_num_divisible_by_k_pkg.sv
// Shared definitions for the divisible-by-K array search: one-hot state
// encodings for the control unit and the search-mode constants.
package largest_num_divisible_by_k_pkg;

  localparam int NUM_STATES = 5;

  typedef logic [NUM_STATES-1:0] state_t;

  // One-hot encodings; bit positions match the Qi/Ql/Qdiv/Qdf/Qdnf outputs.
  localparam state_t S_INI = 5'b00001;
  localparam state_t S_LDX = 5'b00010;
  localparam state_t S_DIV = 5'b00100;
  localparam state_t S_DF  = 5'b01000;
  localparam state_t S_DNF = 5'b10000;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

endpackage

// File: rtl/largest_num_divisible_by_k_check.sv
// Repeated-subtraction divisibility tester: holds the working value X,
// loads it from the array or subtracts K, and flags X>K / X==K / X<K.
module divisible_check_k
  import largest_num_divisible_by_k_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         sub_i,
  input  logic [W-1:0] k_i,
  output logic [W-1:0] x_o,
  output logic         gt_o,
  output logic         eq_o,
  output logic         lt_o
);

  logic [W-1:0] x_q, x_d;

  // Next value of X: load a fresh entry, or subtract K (only issued while X>K).
  always_comb begin
    // NOTE: default first so every path assigns x_d and no latch is inferred.
    x_d = x_q;
    if (load_i) begin
      x_d = load_val_i;
    end else if (sub_i) begin
      x_d = x_q - k_i;
    end
  end

  // X register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) begin
      x_q <= '0;
    end else begin
      x_q <= x_d;
    end
  end

  assign x_o  = x_q;
  assign gt_o = (x_q > k_i);
  assign eq_o = (x_q == k_i);
  assign lt_o = (x_q < k_i);

endmodule

// File: rtl/largest_num_divisible_by_k.sv
// Array search for the largest (Mode=0) or smallest (Mode=1) non-zero entry
// divisible by K. Holds the control unit, the array and result registers;
// the divisibility test itself lives in divisible_check_k.
module largest_num_divisible_by_k
  import largest_num_divisible_by_k_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Ack,
  input  logic          Mode,
  input  logic [W-1:0]  Div_K,
  input  logic          Wr_En,
  input  logic [AW-1:0] Wr_Addr,
  input  logic [W-1:0]  Wr_Data,
  output logic [W-1:0]  Result,
  output logic [AW-1:0] Result_Idx,
  output logic          Done,
  output logic          Qi,
  output logic          Ql,
  output logic          Qdiv,
  output logic          Qdf,
  output logic          Qdnf
);

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  result_q, result_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] i_q, i_d;
  logic [W-1:0]  k_q, k_d;
  logic          found_q, found_d;
  logic          mode_q, mode_d;

  logic [W-1:0]  cur;
  logic          last, skip;
  logic          x_load, x_sub;
  logic [W-1:0]  x_val;
  logic          x_gt, x_eq, x_lt;

  assign cur  = mem_q[i_q];
  assign last = (i_q == AW'(DEPTH - 1));
  // Strict compare keeps the first occurrence on ties.
  assign skip = (cur == '0) ||
                (found_q && ((mode_q == MODE_MAX) ? (cur <= result_q)
                                                  : (cur >= result_q)));

  assign x_load = (state_q == S_LDX) && !skip;
  assign x_sub  = (state_q == S_DIV) && x_gt;

  divisible_check_k #(.W(W)) u_check (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .load_i     (x_load),
    .load_val_i (cur),
    .sub_i      (x_sub),
    .k_i        (k_q),
    .x_o        (x_val),
    .gt_o       (x_gt),
    .eq_o       (x_eq),
    .lt_o       (x_lt)
  );

  // Array write port, honoured only while idle.
  always_ff @(posedge Clk) begin
    // NOTE: array storage has no reset; contents are defined only by writes.
    if (state_q == S_INI && Wr_En) begin
      mem_q[Wr_Addr] <= Wr_Data;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_INI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INI: if (Start) state_d = (Div_K == '0) ? S_DNF : S_LDX;
      S_LDX: begin
        if (!skip)     state_d = S_DIV;
        else if (last) state_d = found_q ? S_DF : S_DNF;
      end
      S_DIV: begin
        if (!x_gt) begin
          if (last) state_d = (found_q || x_eq) ? S_DF : S_DNF;
          else      state_d = S_LDX;
        end
      end
      S_DF, S_DNF: if (Ack) state_d = S_INI;
      default: state_d = S_INI;
    endcase
  end

  // Datapath next-state: scan index, latched K/mode, running best result.
  always_comb begin
    result_d = result_q;
    idx_d    = idx_q;
    i_d      = i_q;
    k_d      = k_q;
    found_d  = found_q;
    mode_d   = mode_q;
    case (state_q)
      S_INI: begin
        result_d = '0;
        idx_d    = '0;
        found_d  = 1'b0;
        i_d      = '0;
        if (Start) begin
          k_d    = Div_K;
          mode_d = Mode;
        end
      end
      S_LDX: if (skip && !last) i_d = i_q + 1'b1;
      S_DIV: begin
        if (x_eq) begin
          result_d = cur;
          idx_d    = i_q;
          found_d  = 1'b1;
        end
        if (!x_gt && !last) i_d = i_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      result_q <= '0;
      idx_q    <= '0;
      i_q      <= '0;
      k_q      <= '0;
      found_q  <= 1'b0;
      mode_q   <= MODE_MAX;
    end else begin
      result_q <= result_d;
      idx_q    <= idx_d;
      i_q      <= i_d;
      k_q      <= k_d;
      found_q  <= found_d;
      mode_q   <= mode_d;
    end
  end

  // Outputs: one-hot state flags and the held result.
  always_comb begin
    Qi         = state_q[0];
    Ql         = state_q[1];
    Qdiv       = state_q[2];
    Qdf        = state_q[3];
    Qdnf       = state_q[4];
    Done       = state_q[3] | state_q[4];
    Result     = result_q;
    Result_Idx = idx_q;
  end

  // x_val and x_lt are observation-only: X<K is the implicit "else" of the DIV branch.
  logic unused_ok;
  assign unused_ok = ^{x_val, x_lt};

endmodule

// File: tb/tb_largest_num_divisible_by_k.sv
// Scoreboard bench: each search pushes its expected outcome; a monitor pops
// and compares whenever Done rises.
module tb_largest_num_divisible_by_k;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          Clk = 1'b0;
  logic          Reset_n, Start, Ack, Mode, Wr_En;
  logic [W-1:0]  Div_K, Wr_Data;
  logic [AW-1:0] Wr_Addr;
  logic [W-1:0]  Result;
  logic [AW-1:0] Result_Idx;
  logic          Done, Qi, Ql, Qdiv, Qdf, Qdnf;

  largest_num_divisible_by_k dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack), .Mode(Mode),
    .Div_K(Div_K), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Result(Result), .Result_Idx(Result_Idx), .Done(Done),
    .Qi(Qi), .Ql(Ql), .Qdiv(Qdiv), .Qdf(Qdf), .Qdnf(Qdnf)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [W-1:0]  result;
    logic [AW-1:0] idx;
    logic          found;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each rising Done, compare against the oldest expectation.
  always @(negedge Clk) begin
    if (Done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Result=%0d with no pending search", Result);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_result", Result, mon_e.result);
        check("sb_idx", Result_Idx, mon_e.idx);
        check("sb_qdf", Qdf, mon_e.found);
        check("sb_qdnf", Qdnf, !mon_e.found);
      end
    end
    done_prev = Done;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_mem(input int a, input int d);
    Wr_En   = 1'b1;
    Wr_Addr = a[AW-1:0];
    Wr_Data = d[W-1:0];
    tick();
    Wr_En   = 1'b0;
  endtask

  // Start a search, push its expectation, wait (bounded) for Done, then Ack.
  task automatic run(input string name, input logic [W-1:0] k, input logic m,
                     input int er, input int eidx, input logic ef, input bit disturb,
                     output int ldx_n, output int div_n);
    exp_t e;
    int   cyc;
    e.result = er[W-1:0];
    e.idx    = eidx[AW-1:0];
    e.found  = ef;
    exp_q.push_back(e);
    Div_K = k;
    Mode  = m;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    ldx_n = 0;
    div_n = 0;
    cyc   = 0;
    while (!Done && cyc < 2000) begin
      if (Ql)   ldx_n++;
      if (Qdiv) div_n++;
      if (disturb) begin
        Wr_En   = 1'b1;
        Wr_Addr = '0;
        Wr_Data = 8'd99;
        Div_K   = ~k;
        Mode    = ~m;
      end
      tick();
      cyc++;
    end
    Wr_En = 1'b0;
    check({name, "_done_reached"}, Done, 1);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    check({name, "_qi_after_ack"}, Qi, 1);
  endtask

  int ldx_n, div_n;

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Ack = 1'b0; Mode = 1'b0;
    Div_K = '0; Wr_En = 1'b0; Wr_Addr = '0; Wr_Data = '0;
    tick(); tick();
    check("rst_qi", Qi, 1);
    check("rst_qstates", {Ql, Qdiv, Qdf, Qdnf}, 0);
    check("rst_done", Done, 0);
    check("rst_result", Result, 0);
    check("rst_idx", Result_Idx, 0);
    Reset_n = 1'b1;
    tick();

    // Test 1/2: mixed array, K=7, largest then smallest.
    for (int i = 0; i < DEPTH; i++) write_mem(i, 0);
    write_mem(0, 3); write_mem(1, 14); write_mem(2, 21);
    write_mem(3, 5); write_mem(5, 70); write_mem(6, 9);
    run("t1_max", 8'd7, 1'b0, 70, 5, 1'b1, 1'b0, ldx_n, div_n);
    check("t1_ldx_cycles", ldx_n, 16);
    run("t2_min", 8'd7, 1'b1, 14, 1, 1'b1, 1'b0, ldx_n, div_n);

    // Test 3: all odd values, K=2 -> nothing divisible.
    for (int i = 0; i < DEPTH; i++) write_mem(i, 2 * i + 1);
    run("t3_odd", 8'd2, 1'b0, 0, 0, 1'b0, 1'b0, ldx_n, div_n);

    // Test 4: K=0 goes straight to D_NF.
    run("t4_k0", 8'd0, 1'b0, 0, 0, 1'b0, 1'b0, ldx_n, div_n);
    check("t4_no_ldx", ldx_n, 0);
    check("t4_no_div", div_n, 0);

    // Test 5: 42s with 84 at the top, then all 42s (first occurrence wins).
    for (int i = 0; i < DEPTH - 1; i++) write_mem(i, 42);
    write_mem(15, 84);
    run("t5_top", 8'd42, 1'b0, 84, 15, 1'b1, 1'b0, ldx_n, div_n);
    check("t5_div_cycles", div_n, 3);
    write_mem(15, 42);
    run("t5_tie_disturb", 8'd42, 1'b0, 42, 0, 1'b1, 1'b1, ldx_n, div_n);
    run("t5_tie_again", 8'd42, 1'b0, 42, 0, 1'b1, 1'b0, ldx_n, div_n);
    check("t5_div_cycles_tie", div_n, 1);

    // Test 6: reset mid-DIV, then a K=1 run over 255.
    for (int i = 0; i < DEPTH; i++) write_mem(i, 0);
    write_mem(0, 200);
    write_mem(1, 255);
    Div_K = 8'd1; Mode = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 230; c++) tick();
    check("t6_in_div", Qdiv, 1);
    check("t6_result_before_rst", Result, 200);
    Reset_n = 1'b0;
    #1;
    check("t6_rst_qi", Qi, 1);
    check("t6_rst_done", Done, 0);
    check("t6_rst_result", Result, 0);
    check("t6_rst_qdiv", Qdiv, 0);
    tick();
    Reset_n = 1'b1;
    tick();
    write_mem(0, 0);
    run("t6_k1", 8'd1, 1'b0, 255, 1, 1'b1, 1'b0, ldx_n, div_n);
    check("t6_div_cycles", div_n, 255);
    check("t6_ldx_cycles", ldx_n, 16);

    tick(); tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
